// File: rtl/reg_scoreboard.sv
// reg_scoreboard: issue-side hazard tracking for reg_file plus round-robin
// arbitration of the single reg_file write port between ALU and LSU writebacks.
module reg_scoreboard #(
  parameter int REG_COUNT       = 32,
  parameter int WORD_SIZE       = 32,
  parameter int REG_ADDR_W      = $clog2(REG_COUNT),
  parameter int OUTSTANDING_MAX = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  issue_valid_i,
  output logic                  issue_ready_o,
  input  logic [REG_ADDR_W-1:0] issue_rs0_i,
  input  logic [REG_ADDR_W-1:0] issue_rs1_i,
  input  logic [REG_ADDR_W-1:0] issue_rd_i,
  input  logic                  issue_wr_en_i,
  input  logic                  issue_src_i,
  input  logic                  alu_wb_valid_i,
  output logic                  alu_wb_ready_o,
  input  logic [REG_ADDR_W-1:0] alu_wb_rd_i,
  input  logic [WORD_SIZE-1:0]  alu_wb_data_i,
  input  logic                  lsu_wb_valid_i,
  output logic                  lsu_wb_ready_o,
  input  logic [REG_ADDR_W-1:0] lsu_wb_rd_i,
  input  logic [WORD_SIZE-1:0]  lsu_wb_data_i,
  output logic                  reg_write_o,
  output logic [REG_ADDR_W-1:0] write_reg_o,
  output logic [WORD_SIZE-1:0]  write_data_o,
  output logic [REG_COUNT-1:0]  busy_o,
  output logic                  err_o
);

  localparam int CNT_W = $clog2(OUTSTANDING_MAX + 1);

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } wb_src_e;

  logic [REG_COUNT-1:0]  busy_q;
  logic [REG_COUNT-1:0]  owner_q;
  logic [CNT_W-1:0]      count_q;
  wb_src_e               rr_ptr_q;

  logic                  count_full;
  logic                  issue_set;
  logic                  contend;
  logic                  gnt_any;
  logic                  gnt_src;
  logic [REG_ADDR_W-1:0] gnt_rd;
  logic [WORD_SIZE-1:0]  gnt_data;
  logic                  gnt_retiring;
  logic                  wb_match;
  logic                  commit;
  logic                  wb_err;

  assign busy_o     = busy_q;
  assign count_full = (count_q == CNT_W'(OUTSTANDING_MAX));

  // Issue gate: RAW on either source, WAW on rd, or no free outstanding slot.
  always_comb begin
    issue_ready_o = !busy_q[issue_rs0_i] && !busy_q[issue_rs1_i]
                 && !(issue_wr_en_i && busy_q[issue_rd_i])
                 && !(issue_wr_en_i && (issue_rd_i != '0) && count_full);
    issue_set     = issue_valid_i && issue_ready_o && issue_wr_en_i && (issue_rd_i != '0);
  end

  // Write-port arbitration and legality of the granted writeback.
  always_comb begin
    contend        = alu_wb_valid_i && lsu_wb_valid_i;
    alu_wb_ready_o = alu_wb_valid_i && (!lsu_wb_valid_i || (rr_ptr_q == SRC_ALU));
    lsu_wb_ready_o = lsu_wb_valid_i && (!alu_wb_valid_i || (rr_ptr_q == SRC_LSU));
    gnt_any        = alu_wb_ready_o || lsu_wb_ready_o;
    gnt_src        = lsu_wb_ready_o;
    gnt_rd         = lsu_wb_ready_o ? lsu_wb_rd_i   : alu_wb_rd_i;
    gnt_data       = lsu_wb_ready_o ? lsu_wb_data_i : alu_wb_data_i;
    // A register whose commit is already on the write port stays busy for one
    // more cycle but is no longer awaiting a writeback; a second one is illegal.
    gnt_retiring   = reg_write_o && (write_reg_o == gnt_rd);
    wb_match       = busy_q[gnt_rd] && !gnt_retiring && (owner_q[gnt_rd] == gnt_src);
    commit         = gnt_any && (gnt_rd != '0) && wb_match;
    wb_err         = gnt_any && (gnt_rd != '0) && !wb_match;
  end

  // Pending-register bookkeeping, outstanding count, arbitration pointer, error flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q   <= '0;
      owner_q  <= '0;
      count_q  <= '0;
      rr_ptr_q <= SRC_ALU;
      err_o    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here; the two indexed busy updates read
      // pre-edge state and can never target the same bit (WAW blocks the issue).
      if (reg_write_o) begin
        busy_q[write_reg_o] <= 1'b0;
      end
      if (issue_set) begin
        busy_q[issue_rd_i]  <= 1'b1;
        owner_q[issue_rd_i] <= issue_src_i;
      end
      case ({issue_set, reg_write_o})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (contend) begin
        rr_ptr_q <= (rr_ptr_q == SRC_ALU) ? SRC_LSU : SRC_ALU;
      end
      if (wb_err) begin
        err_o <= 1'b1;
      end
    end
  end

  // Registered reg_file write port; index and data hold when nothing commits.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: the data register is reset too, so the write port never shows X.
      reg_write_o  <= 1'b0;
      write_reg_o  <= '0;
      write_data_o <= '0;
    end else begin
      reg_write_o <= commit;
      if (commit) begin
        write_reg_o  <= gnt_rd;
        write_data_o <= gnt_data;
      end
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_reg_scoreboard;

  localparam int RC   = 32;
  localparam int WS   = 32;
  localparam int AW   = 5;
  localparam int OMAX = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          issue_valid_i, issue_ready_o;
  logic [AW-1:0] issue_rs0_i, issue_rs1_i, issue_rd_i;
  logic          issue_wr_en_i, issue_src_i;
  logic          alu_wb_valid_i, alu_wb_ready_o;
  logic [AW-1:0] alu_wb_rd_i;
  logic [WS-1:0] alu_wb_data_i;
  logic          lsu_wb_valid_i, lsu_wb_ready_o;
  logic [AW-1:0] lsu_wb_rd_i;
  logic [WS-1:0] lsu_wb_data_i;
  logic          reg_write_o;
  logic [AW-1:0] write_reg_o;
  logic [WS-1:0] write_data_o;
  logic [RC-1:0] busy_o;
  logic          err_o;

  int checks = 0;
  int errors = 0;

  reg_scoreboard #(
    .REG_COUNT(RC), .WORD_SIZE(WS), .REG_ADDR_W(AW), .OUTSTANDING_MAX(OMAX)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_rs0_i(issue_rs0_i), .issue_rs1_i(issue_rs1_i), .issue_rd_i(issue_rd_i),
    .issue_wr_en_i(issue_wr_en_i), .issue_src_i(issue_src_i),
    .alu_wb_valid_i(alu_wb_valid_i), .alu_wb_ready_o(alu_wb_ready_o),
    .alu_wb_rd_i(alu_wb_rd_i), .alu_wb_data_i(alu_wb_data_i),
    .lsu_wb_valid_i(lsu_wb_valid_i), .lsu_wb_ready_o(lsu_wb_ready_o),
    .lsu_wb_rd_i(lsu_wb_rd_i), .lsu_wb_data_i(lsu_wb_data_i),
    .reg_write_o(reg_write_o), .write_reg_o(write_reg_o), .write_data_o(write_data_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock: inputs are changed 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid_i = 0; issue_rs0_i = 0; issue_rs1_i = 0; issue_rd_i = 0;
    issue_wr_en_i = 0; issue_src_i = 0;
    alu_wb_valid_i = 0; alu_wb_rd_i = 0; alu_wb_data_i = 0;
    lsu_wb_valid_i = 0; lsu_wb_rd_i = 0; lsu_wb_data_i = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1;
    cyc();
    rst_i = 0;
  endtask

  task automatic issue(input int rd, input bit src);
    idle_inputs();
    issue_valid_i = 1; issue_rd_i = AW'(rd); issue_wr_en_i = 1; issue_src_i = src;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          iv;
    logic [AW-1:0] rs0, rd;
    logic          we, src;
    logic          av;
    logic [AW-1:0] ard;
    logic [WS-1:0] adata;
    logic          lv;
    logic [AW-1:0] lrd;
    logic [WS-1:0] ldata;
    logic          e_ready, e_ag, e_lg, e_we;
    logic [AW-1:0] e_wreg;
    logic [WS-1:0] e_wdata;
    logic [RC-1:0] e_busy;
    logic          e_err;
  } vec_t;

  vec_t vecs[12];

  // ---------------- behavioural model ----------------
  // Per-register life cycle: 0 free, 1 awaiting writeback, 2 writeback on the port.
  int            m_stat[RC];
  bit            m_own[RC];
  bit            m_ptr_lsu;
  bit            m_err;
  bit            m_we;
  int            m_reg;
  logic [WS-1:0] m_data;

  task automatic m_reset();
    for (int r = 0; r < RC; r++) begin m_stat[r] = 0; m_own[r] = 0; end
    m_ptr_lsu = 0; m_err = 0; m_we = 0; m_reg = 0; m_data = 0;
  endtask

  function automatic bit m_busy(input int r);
    return m_stat[r] != 0;
  endfunction

  function automatic int m_nbusy();
    int n = 0;
    for (int r = 0; r < RC; r++) if (m_stat[r] != 0) n++;
    return n;
  endfunction

  function automatic logic [RC-1:0] m_busy_vec();
    logic [RC-1:0] v = '0;
    for (int r = 0; r < RC; r++) v[r] = (m_stat[r] != 0);
    return v;
  endfunction

  initial begin
    logic e_ready, e_ag, e_lg, g_any, g_src, legal;
    int   g_rd;
    logic [WS-1:0] g_data;
    int   prev_rd;
    int   a_rds[4], l_rds[4];
    bit   lsu_wins[4];

    rst_i = 1;
    idle_inputs();
    cyc();
    rst_i = 0;

    // ----- Table: reset state, RAW stall/unblock timing, rd=0 and error traffic -----
    //          iv rs0 rd we src  av ard adata          lv lrd ldata   rdy ag lg we wreg wdata          busy        err
    vecs[0]  = '{0, 0, 0, 0, 0,  0, 0, 32'h0,          0, 0, 32'h0,  1, 0, 0, 0, 0, 32'h0,          32'h0,      0};
    vecs[1]  = '{1, 0, 5, 1, 0,  0, 0, 32'h0,          0, 0, 32'h0,  1, 0, 0, 0, 0, 32'h0,          32'h0,      0};
    vecs[2]  = '{1, 5, 0, 0, 0,  0, 0, 32'h0,          0, 0, 32'h0,  0, 0, 0, 0, 0, 32'h0,          32'h20,     0};
    vecs[3]  = '{1, 5, 0, 0, 0,  1, 5, 32'hDEADBEEF,   0, 0, 32'h0,  0, 1, 0, 0, 0, 32'h0,          32'h20,     0};
    vecs[4]  = '{1, 5, 0, 0, 0,  0, 0, 32'h0,          0, 0, 32'h0,  0, 0, 0, 1, 5, 32'hDEADBEEF,   32'h20,     0};
    vecs[5]  = '{1, 5, 0, 0, 0,  0, 0, 32'h0,          0, 0, 32'h0,  1, 0, 0, 0, 5, 32'hDEADBEEF,   32'h0,      0};
    vecs[6]  = '{0, 0, 0, 0, 0,  0, 0, 32'h0,          1, 0, 32'h1,  1, 0, 1, 0, 5, 32'hDEADBEEF,   32'h0,      0};
    vecs[7]  = '{0, 0, 0, 0, 0,  1, 9, 32'h2,          0, 0, 32'h0,  1, 1, 0, 0, 5, 32'hDEADBEEF,   32'h0,      0};
    vecs[8]  = '{0, 0, 0, 0, 0,  0, 0, 32'h0,          1, 0, 32'h3,  1, 0, 1, 0, 5, 32'hDEADBEEF,   32'h0,      1};
    vecs[9]  = '{0, 0, 0, 0, 0,  1, 9, 32'h4,          1, 9, 32'h5,  1, 1, 0, 0, 5, 32'hDEADBEEF,   32'h0,      1};
    vecs[10] = '{0, 0, 0, 0, 0,  1, 0, 32'h6,          1, 0, 32'h7,  1, 0, 1, 0, 5, 32'hDEADBEEF,   32'h0,      1};
    vecs[11] = '{0, 0, 0, 0, 0,  0, 0, 32'h0,          0, 0, 32'h0,  1, 0, 0, 0, 5, 32'hDEADBEEF,   32'h0,      1};

    for (int i = 0; i < 12; i++) begin
      idle_inputs();
      issue_valid_i = vecs[i].iv; issue_rs0_i = vecs[i].rs0; issue_rd_i = vecs[i].rd;
      issue_wr_en_i = vecs[i].we; issue_src_i = vecs[i].src;
      alu_wb_valid_i = vecs[i].av; alu_wb_rd_i = vecs[i].ard; alu_wb_data_i = vecs[i].adata;
      lsu_wb_valid_i = vecs[i].lv; lsu_wb_rd_i = vecs[i].lrd; lsu_wb_data_i = vecs[i].ldata;
      #3;
      check($sformatf("v%0d.issue_ready", i), 64'(issue_ready_o),  64'(vecs[i].e_ready));
      check($sformatf("v%0d.alu_ready", i),   64'(alu_wb_ready_o), 64'(vecs[i].e_ag));
      check($sformatf("v%0d.lsu_ready", i),   64'(lsu_wb_ready_o), 64'(vecs[i].e_lg));
      check($sformatf("v%0d.reg_write", i),   64'(reg_write_o),    64'(vecs[i].e_we));
      check($sformatf("v%0d.write_reg", i),   64'(write_reg_o),    64'(vecs[i].e_wreg));
      check($sformatf("v%0d.write_data", i),  64'(write_data_o),   64'(vecs[i].e_wdata));
      check($sformatf("v%0d.busy", i),        64'(busy_o),         64'(vecs[i].e_busy));
      check($sformatf("v%0d.err", i),         64'(err_o),          64'(vecs[i].e_err));
      cyc();
    end

    // ----- Arbitration: simultaneous first grant, then held contention alternates -----
    do_reset();
    issue(3, 0); cyc();
    issue(7, 1); cyc();
    idle_inputs();
    alu_wb_valid_i = 1; alu_wb_rd_i = 3; alu_wb_data_i = 32'h33;
    lsu_wb_valid_i = 1; lsu_wb_rd_i = 7; lsu_wb_data_i = 32'h77;
    #3;
    check("arb.first_alu", 64'(alu_wb_ready_o), 64'd1);
    check("arb.first_lsu", 64'(lsu_wb_ready_o), 64'd0);
    cyc();
    alu_wb_valid_i = 0;
    #3;
    check("arb.then_lsu", 64'(lsu_wb_ready_o), 64'd1);
    check("arb.x3_write", 64'(write_reg_o), 64'd3);
    cyc();
    idle_inputs();
    #3;
    check("arb.x7_write", 64'(reg_write_o), 64'd1);
    check("arb.x7_data", 64'(write_data_o), 64'h77);
    check("arb.x7_busy", 64'(busy_o), 64'h80);
    cyc();
    issue(10, 0); #3; check("arb.iss10", 64'(issue_ready_o), 64'd1); cyc();
    issue(11, 1); cyc();
    issue(12, 0); cyc();
    issue(13, 1); cyc();
    a_rds = '{10, 10, 12, 12};
    l_rds = '{11, 13, 13, 13};
    lsu_wins = '{1, 0, 1, 0};
    prev_rd = -1;
    for (int c = 0; c < 4; c++) begin
      idle_inputs();
      alu_wb_valid_i = 1; alu_wb_rd_i = AW'(a_rds[c]); alu_wb_data_i = 32'(a_rds[c]);
      lsu_wb_valid_i = 1; lsu_wb_rd_i = AW'(l_rds[c]); lsu_wb_data_i = 32'(l_rds[c]);
      #3;
      check($sformatf("rr%0d.lsu", c), 64'(lsu_wb_ready_o), 64'(lsu_wins[c]));
      check($sformatf("rr%0d.alu", c), 64'(alu_wb_ready_o), 64'(!lsu_wins[c]));
      if (prev_rd >= 0) check($sformatf("rr%0d.prev_write", c), 64'(write_reg_o), 64'(prev_rd));
      prev_rd = lsu_wins[c] ? l_rds[c] : a_rds[c];
      cyc();
    end
    idle_inputs();
    #3;
    check("rr.last_write", 64'(write_reg_o), 64'd12);
    check("rr.busy_tail", 64'(busy_o), 64'h1000);
    cyc();
    #3;
    check("rr.busy_clear", 64'(busy_o), 64'h0);
    check("rr.no_err", 64'(err_o), 64'd0);

    // ----- Outstanding limit -----
    do_reset();
    for (int r = 1; r <= 4; r++) begin
      issue(r, 0); #3;
      check($sformatf("lim.iss%0d", r), 64'(issue_ready_o), 64'd1);
      cyc();
    end
    issue(6, 0); #3; check("lim.rd6_stall", 64'(issue_ready_o), 64'd0); cyc();
    idle_inputs(); issue_valid_i = 1; issue_rs0_i = 8; #3;
    check("lim.nowrite_ok", 64'(issue_ready_o), 64'd1); cyc();
    issue(6, 0); alu_wb_valid_i = 1; alu_wb_rd_i = 1; alu_wb_data_i = 32'h11; #3;
    check("lim.wb_grant", 64'(alu_wb_ready_o), 64'd1);
    check("lim.rd6_N", 64'(issue_ready_o), 64'd0);
    cyc();
    issue(6, 0); #3;
    check("lim.rd6_N1", 64'(issue_ready_o), 64'd0);
    check("lim.commit", 64'(reg_write_o), 64'd1);
    cyc();
    #3; check("lim.rd6_N2", 64'(issue_ready_o), 64'd1); cyc();
    issue(7, 0); #3;
    check("lim.busy", 64'(busy_o), 64'h5C);
    check("lim.full_again", 64'(issue_ready_o), 64'd0);
    cyc();

    // ----- Reset mid-operation -----
    do_reset();
    issue(1, 0); cyc();
    issue(2, 0); cyc();
    issue(3, 0); cyc();
    idle_inputs(); alu_wb_valid_i = 1; alu_wb_rd_i = 1; alu_wb_data_i = 32'hAB; rst_i = 1; #3;
    check("rst.grant", 64'(alu_wb_ready_o), 64'd1);
    check("rst.busy_before", 64'(busy_o), 64'hE);
    cyc();
    rst_i = 0; issue(2, 0); issue_rs0_i = 1; #3;
    check("rst.busy", 64'(busy_o), 64'h0);
    check("rst.reg_write", 64'(reg_write_o), 64'd0);
    check("rst.ready", 64'(issue_ready_o), 64'd1);
    check("rst.data", 64'(write_data_o), 64'h0);
    cyc();

    // ----- Randomized run against the model -----
    do_reset();
    m_reset();
    for (int n = 0; n < 800; n++) begin
      rst_i          = ($urandom_range(59, 0) == 0);
      issue_valid_i  = ($urandom_range(3, 0) != 0);
      issue_rs0_i    = AW'($urandom_range(7, 0));
      issue_rs1_i    = AW'($urandom_range(7, 0));
      issue_rd_i     = AW'($urandom_range(7, 0));
      issue_wr_en_i  = ($urandom_range(3, 0) != 0);
      issue_src_i    = 1'($urandom_range(1, 0));
      alu_wb_valid_i = ($urandom_range(2, 0) == 0);
      alu_wb_rd_i    = AW'($urandom_range(7, 0));
      alu_wb_data_i  = $urandom;
      lsu_wb_valid_i = ($urandom_range(2, 0) == 0);
      lsu_wb_rd_i    = AW'($urandom_range(7, 0));
      lsu_wb_data_i  = $urandom;
      #3;
      e_ready = !m_busy(int'(issue_rs0_i)) && !m_busy(int'(issue_rs1_i))
             && !(issue_wr_en_i && m_busy(int'(issue_rd_i)))
             && !(issue_wr_en_i && issue_rd_i != 0 && m_nbusy() == OMAX);
      if (alu_wb_valid_i && lsu_wb_valid_i) begin
        e_ag = !m_ptr_lsu; e_lg = m_ptr_lsu;
      end else begin
        e_ag = alu_wb_valid_i; e_lg = lsu_wb_valid_i;
      end
      check($sformatf("rnd%0d.issue_ready", n), 64'(issue_ready_o),  64'(e_ready));
      check($sformatf("rnd%0d.alu_ready", n),   64'(alu_wb_ready_o), 64'(e_ag));
      check($sformatf("rnd%0d.lsu_ready", n),   64'(lsu_wb_ready_o), 64'(e_lg));
      check($sformatf("rnd%0d.reg_write", n),   64'(reg_write_o),    64'(m_we));
      check($sformatf("rnd%0d.write_reg", n),   64'(write_reg_o),    64'(m_reg));
      check($sformatf("rnd%0d.write_data", n),  64'(write_data_o),   64'(m_data));
      check($sformatf("rnd%0d.busy", n),        64'(busy_o),         64'(m_busy_vec()));
      check($sformatf("rnd%0d.err", n),         64'(err_o),          64'(m_err));

      // Model update for the coming edge.
      if (rst_i) begin
        m_reset();
      end else begin
        g_any  = e_ag || e_lg;
        g_src  = e_lg;
        g_rd   = e_lg ? int'(lsu_wb_rd_i) : int'(alu_wb_rd_i);
        g_data = e_lg ? lsu_wb_data_i : alu_wb_data_i;
        legal  = (m_stat[g_rd] == 1) && (m_own[g_rd] == g_src);
        if (m_we) m_stat[m_reg] = 0;
        m_we = 0;
        if (g_any && g_rd != 0) begin
          if (legal) begin
            m_stat[g_rd] = 2; m_we = 1; m_reg = g_rd; m_data = g_data;
          end else begin
            m_err = 1;
          end
        end
        if (alu_wb_valid_i && lsu_wb_valid_i) m_ptr_lsu = !m_ptr_lsu;
        if (issue_valid_i && e_ready && issue_wr_en_i && issue_rd_i != 0) begin
          m_stat[issue_rd_i] = 1; m_own[issue_rd_i] = issue_src_i;
        end
      end
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
